cla_serial_sequencer: RTL and testbench

Multi-cycle WIDTH-bit add/subtract controller that sits directly upstream and downstream of the team's 4-bit carry-lookahead adder.
- Accepts full-width operands over a valid/ready handshake.
- Drives one nibble per cycle into the external 4-bit adder.
- Captures the adder's SUM/C_OUT, chains the carry between cycles, and returns the full-width result with carry and signed overflow over a second valid/ready handshake.

---
 rtl/cla_serial_sequencer_pkg.sv | 12 +
 rtl/cla_serial_sequencer_nibble_mux.sv | 18 +
 rtl/cla_serial_sequencer.sv | 141 ++++++++++++++
 tb/tb_cla_serial_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package cla_serial_sequencer_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_serial_sequencer_nibble_mux.sv
// Picks one NIB_W-bit slice out of a WIDTH-bit word by nibble index.
module cla_serial_sequencer_nibble_mux
    import cla_serial_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 2
) (
    input  logic [WIDTH-1:0] data,
    input  logic [IDX_W-1:0] idx,
    output logic [NIB_W-1:0] nib_c
);

    logic [WIDTH/NIB_W-1:0][NIB_W-1:0] nibs;

    assign nibs  = data;
    assign nib_c = nibs[idx];

endmodule

// File: rtl/cla_serial_sequencer.sv
// Feeds full-width operands one nibble per cycle through an external 4-bit
// carry-lookahead adder, chaining the carry and collecting the result.
module cla_serial_sequencer
    import cla_serial_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             OP_CIN,
    input  logic             SUB,
    output logic [NIB_W-1:0] ADD_A,
    output logic [NIB_W-1:0] ADD_B,
    output logic             ADD_CIN,
    input  logic [NIB_W-1:0] ADD_SUM,
    input  logic             ADD_COUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    state_e                          state_q, state_d;
    logic [WIDTH-1:0]                a_q, a_d;
    logic [WIDTH-1:0]                b_q, b_d;
    logic                            carry_q, carry_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NIBBLES-1:0][NIB_W-1:0]   result_q, result_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;
    logic                            out_valid_q, out_valid_d;
    logic [NIB_W-1:0]                nib_a_c, nib_b_c;

    cla_serial_sequencer_nibble_mux #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_mux_a (
        .data  (a_q),
        .idx   (idx_q),
        .nib_c (nib_a_c)
    );

    cla_serial_sequencer_nibble_mux #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_mux_b (
        .data  (b_q),
        .idx   (idx_q),
        .nib_c (nib_b_c)
    );

    // Next-state and datapath update; b is stored pre-inverted for subtract.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = OP_A;
                    b_d     = SUB ? ~OP_B : OP_B;
                    carry_d = SUB ? 1'b1 : OP_CIN;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q] = ADD_SUM;
                carry_d         = ADD_COUT;
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = ADD_COUT;
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (ADD_SUM[NIB_W-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Adder drive is live only while running so the adder sees zeros otherwise.
    always_comb begin
        ADD_A   = '0;
        ADD_B   = '0;
        ADD_CIN = 1'b0;
        if (state_q == RUN) begin
            ADD_A   = nib_a_c;
            ADD_B   = nib_b_c;
            ADD_CIN = carry_q;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign CARRY     = cout_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_cla_serial_sequencer.sv
// Directed plus random checks of the sequencer wrapped around a 4-bit CLA.
module tb_cla_serial_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] OP_A;
    logic [15:0] OP_B;
    logic        OP_CIN;
    logic        SUB;
    logic [3:0]  ADD_A;
    logic [3:0]  ADD_B;
    logic        ADD_CIN;
    logic [3:0]  ADD_SUM;
    logic        ADD_COUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] RESULT;
    logic        CARRY;
    logic        OVERFLOW;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    cla_serial_sequencer #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .OP_CIN    (OP_CIN),
        .SUB       (SUB),
        .ADD_A     (ADD_A),
        .ADD_B     (ADD_B),
        .ADD_CIN   (ADD_CIN),
        .ADD_SUM   (ADD_SUM),
        .ADD_COUT  (ADD_COUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW)
    );

    // 4-bit carry-lookahead adder in the loop.
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = ADD_A & ADD_B;
    assign p = ADD_A ^ ADD_B;
    assign c[0] = ADD_CIN;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign ADD_SUM  = p ^ c[3:0];
    assign ADD_COUT = c[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (IN_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("in_ready_wait", 32'(IN_READY), 32'd1);
    endtask

    // One full transaction; hold = cycles OUT_READY stays low in DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input int hold);
        logic [15:0]  bx;
        logic         c0;
        logic [16:0]  full;
        int           sr;
        logic         exp_ovf;
        int unsigned  mask, low;
        bx   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = 17'(a) + 17'(bx) + 17'(c0);
        sr   = sub ? (int'($signed(a)) - int'($signed(b)))
                   : (int'($signed(a)) + int'($signed(b)) + int'(cin));
        exp_ovf = (sr > 32767) || (sr < -32768);

        wait_ready();
        OUT_READY = (hold == 0);
        IN_VALID  = 1'b1;
        OP_A      = a;
        OP_B      = b;
        OP_CIN    = cin;
        SUB       = sub;
        @(posedge CLK);
        #1;
        IN_VALID = 1'($urandom);
        OP_A     = 16'($urandom);
        OP_B     = 16'($urandom);
        OP_CIN   = 1'($urandom);
        SUB      = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            mask = (32'd1 << (4 * k)) - 32'd1;
            low  = (32'(a) & mask) + (32'(bx) & mask) + 32'(c0);
            chk("run_add_a", 32'(ADD_A), 32'(a[4*k +: 4]));
            chk("run_add_b", 32'(ADD_B), 32'(bx[4*k +: 4]));
            chk("run_add_cin", 32'(ADD_CIN), (low >> (4 * k)) & 32'd1);
            chk("run_out_valid", 32'(OUT_VALID), 32'd0);
            chk("run_in_ready", 32'(IN_READY), 32'd0);
            @(posedge CLK);
            #1;
            IN_VALID = (k < 3) ? 1'($urandom) : 1'b0;
            OP_A     = 16'($urandom);
        end
        @(negedge CLK);
        chk("done_out_valid", 32'(OUT_VALID), 32'd1);
        chk("done_result", 32'(RESULT), 32'(full[15:0]));
        chk("done_carry", 32'(CARRY), 32'(full[16]));
        chk("done_overflow", 32'(OVERFLOW), 32'(exp_ovf));
        chk("done_in_ready", 32'(IN_READY), 32'd0);
        chk("done_add_a", 32'(ADD_A), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK);
            #1;
            IN_VALID = ~IN_VALID;
            OP_A     = ~OP_A;
            @(negedge CLK);
            chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
            chk("bp_result", 32'(RESULT), 32'(full[15:0]));
            chk("bp_carry", 32'(CARRY), 32'(full[16]));
            chk("bp_overflow", 32'(OVERFLOW), 32'(exp_ovf));
            chk("bp_in_ready", 32'(IN_READY), 32'd0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("release_out_valid", 32'(OUT_VALID), 32'd0);
        chk("release_in_ready", 32'(IN_READY), 32'd1);
    endtask

    initial begin
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OP_A      = '0;
        OP_B      = '0;
        OP_CIN    = 1'b0;
        SUB       = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_result", 32'(RESULT), 32'd0);
        chk("rst_carry", 32'(CARRY), 32'd0);
        chk("rst_overflow", 32'(OVERFLOW), 32'd0);
        chk("rst_add", 32'({ADD_A, ADD_B, ADD_CIN}), 32'd0);
        RST = 1'b0;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 3);

        // Abort in RUN at nibble index 2.
        wait_ready();
        IN_VALID = 1'b1;
        OP_A     = 16'h1111;
        OP_B     = 16'h2222;
        OP_CIN   = 1'b0;
        SUB      = 1'b0;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_idx2_add_a", 32'(ADD_A), 32'h1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_in_ready", 32'(IN_READY), 32'd1);
        chk("abort_out_valid", 32'(OUT_VALID), 32'd0);
        chk("abort_result", 32'(RESULT), 32'd0);
        chk("abort_flags", 32'({CARRY, OVERFLOW}), 32'd0);
        chk("abort_add", 32'({ADD_A, ADD_B, ADD_CIN}), 32'd0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
